// File: rtl/nibble_io_port_if.sv
// uP-side I/O bus of the nibble port: IN read strobe/data/valid and OUT write strobe/data.
// The uP core is the master; nibble_io_port is the slave.
interface nibble_io_port_if #(
    parameter int WIDTH = 4
) ();
    logic             in_rd;
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             out_wr;
    logic [WIDTH-1:0] out_data;

    modport master (
        output in_rd,
        output out_wr,
        output out_data,
        input  in_data,
        input  in_valid
    );

    modport slave (
        input  in_rd,
        input  out_wr,
        input  out_data,
        output in_data,
        output in_valid
    );
endinterface

// File: rtl/nibble_io_port.sv
// nibble_io_port: pushbutton input side (2-FF sync, per-bit debounce, press latches
// read by the uP IN strobe) and LED output side (nibble captured on the OUT strobe).
// Every bit is an independent copy of the same logic; bits never interact.
module nibble_io_port #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] PUSHBUTTONS,
    output logic [WIDTH-1:0] FF_OUT,
    output logic [WIDTH-1:0] btn_level,
    output logic             evt_pending,
    nibble_io_port_if.slave  bus
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync1_r;
    logic [WIDTH-1:0] sync2_r;
    logic [WIDTH-1:0] level_r;
    logic [WIDTH-1:0] latch_r;
    logic [CW-1:0]    cnt_r [WIDTH];
    logic [WIDTH-1:0] in_data_r;
    logic             in_valid_r;
    logic [WIDTH-1:0] ff_out_r;
    logic             evt_r;

    logic [WIDTH-1:0] level_nxt_s;
    logic [CW-1:0]    cnt_nxt_s [WIDTH];
    logic [WIDTH-1:0] rise_s;
    logic [WIDTH-1:0] latch_nxt_s;
    logic [WIDTH-1:0] read_val_s;

    // Next debounce level/count per bit, press-latch update and the value an IN read returns.
    always_comb begin
        level_nxt_s = level_r;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_nxt_s[i] = CNT_ZERO;
        end
        for (int i = 0; i < WIDTH; i++) begin
            if (sync2_r[i] == level_r[i]) begin
                // Input agrees with accepted level: any partial count is discarded.
                cnt_nxt_s[i]   = CNT_ZERO;
                level_nxt_s[i] = level_r[i];
            end else if (cnt_r[i] == CNT_LAST) begin
                // Disagreement held long enough: accept the new level.
                cnt_nxt_s[i]   = CNT_ZERO;
                level_nxt_s[i] = sync2_r[i];
            end else begin
                cnt_nxt_s[i]   = cnt_r[i] + CNT_ONE;
                level_nxt_s[i] = level_r[i];
            end
        end

        rise_s = level_nxt_s & ~level_r;

        // A read clears the latches, but a press accepted on the same edge survives it.
        if (bus.in_rd) begin
            latch_nxt_s = rise_s;
        end else begin
            latch_nxt_s = latch_r | rise_s;
        end

        read_val_s = level_r | latch_r;
    end

    // All state: synchronizer, debounce, latches, IN/OUT registers; reset clears everything.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_r    <= {WIDTH{1'b0}};
            sync2_r    <= {WIDTH{1'b0}};
            level_r    <= {WIDTH{1'b0}};
            latch_r    <= {WIDTH{1'b0}};
            in_data_r  <= {WIDTH{1'b0}};
            in_valid_r <= 1'b0;
            ff_out_r   <= {WIDTH{1'b0}};
            evt_r      <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_r[i] <= CNT_ZERO;
            end
        end else begin
            sync1_r    <= PUSHBUTTONS;
            sync2_r    <= sync1_r;
            level_r    <= level_nxt_s;
            latch_r    <= latch_nxt_s;
            evt_r      <= |latch_nxt_s;
            in_valid_r <= bus.in_rd;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_r[i] <= cnt_nxt_s[i];
            end
            if (bus.in_rd) begin
                in_data_r <= read_val_s;
            end else begin
                in_data_r <= in_data_r;
            end
            if (bus.out_wr) begin
                ff_out_r <= bus.out_data;
            end else begin
                ff_out_r <= ff_out_r;
            end
        end
    end

    assign bus.in_data  = in_data_r;
    assign bus.in_valid = in_valid_r;
    assign FF_OUT       = ff_out_r;
    assign btn_level    = level_r;
    assign evt_pending  = evt_r;

endmodule

// File: tb/tb_nibble_io_port.sv
// Bench for nibble_io_port: directed scenarios plus randomized traffic, checked against a
// history-based reference model with a scoreboard queue for IN read responses.
module tb_nibble_io_port;

    localparam int W  = 4;
    localparam int DC = 4;

    logic         clk;
    logic         reset;
    logic [W-1:0] pins;
    logic [W-1:0] ff_out;
    logic [W-1:0] btn_level;
    logic         evt_pending;

    nibble_io_port_if #(.WIDTH(W)) bus_if ();

    nibble_io_port #(.WIDTH(W), .DEBOUNCE_CYCLES(DC)) dut (
        .clk         (clk),
        .reset       (reset),
        .PUSHBUTTONS (pins),
        .FF_OUT      (ff_out),
        .btn_level   (btn_level),
        .evt_pending (evt_pending),
        .bus         (bus_if)
    );

    int total = 0;
    int bad   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%b required=%b t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Debounce rule: a bit flips once its synchronized value has disagreed with the
    // accepted level on each of the last DC edges. s2 is the pin value two edges old.
    logic [W-1:0] m_s1, m_s2, m_level, m_latch, m_ff, m_hold, m_nl, m_rise;
    logic         m_valid;
    logic         started = 1'b0;
    logic [W-1:0] m_win[$];
    logic [W-1:0] exp_q[$];

    always @(posedge clk) begin
        started = 1'b1;
        if (!reset) begin
            m_s1 = '0; m_s2 = '0; m_level = '0; m_latch = '0;
            m_ff = '0; m_hold = '0; m_valid = 1'b0;
            m_win.delete();
            for (int j = 0; j < DC; j++) m_win.push_back(4'b0000);
        end else begin
            m_win.push_back(m_s2);
            if (m_win.size() > DC) void'(m_win.pop_front());
            m_nl = m_level;
            for (int b = 0; b < W; b++) begin
                logic flip;
                flip = 1'b1;
                for (int j = 0; j < m_win.size(); j++)
                    if (m_win[j][b] == m_level[b]) flip = 1'b0;
                if (flip) m_nl[b] = ~m_level[b];
            end
            m_rise = m_nl & ~m_level;
            if (bus_if.in_rd) begin
                exp_q.push_back(m_level | m_latch);
                m_hold  = m_level | m_latch;
                m_latch = m_rise;
                m_valid = 1'b1;
            end else begin
                m_latch = m_latch | m_rise;
                m_valid = 1'b0;
            end
            if (bus_if.out_wr) m_ff = bus_if.out_data;
            m_level = m_nl;
            m_s2 = m_s1;
            m_s1 = pins;
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (started) begin
            chk("btn_level", btn_level, m_level);
            chk("ff_out", ff_out, m_ff);
            chk("evt_pending", {3'b000, evt_pending}, {3'b000, |m_latch});
            chk("in_valid", {3'b000, bus_if.in_valid}, {3'b000, m_valid});
            if (bus_if.in_valid) begin
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL in_data_unexpected actual=%b required=none t=%0t",
                             bus_if.in_data, $time);
                end else begin
                    chk("in_data", bus_if.in_data, exp_q.pop_front());
                end
            end else begin
                chk("in_data_hold", bus_if.in_data, m_hold);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_read();
        bus_if.in_rd = 1'b1;
        @(negedge clk);
        bus_if.in_rd = 1'b0;
    endtask

    int hold_cnt;

    initial begin
        reset = 1'b0; pins = 4'b1111;
        bus_if.in_rd = 1'b0; bus_if.out_wr = 1'b1; bus_if.out_data = 4'b1111;

        // 1: reset held for two edges, then full debounce of 1111
        cycles(2);
        #2;
        chk("t1_ff_out", ff_out, 4'b0000);
        chk("t1_level", btn_level, 4'b0000);
        chk("t1_evt", {3'b000, evt_pending}, 4'b0000);
        chk("t1_valid", {3'b000, bus_if.in_valid}, 4'b0000);
        reset = 1'b1; bus_if.out_wr = 1'b0;
        cycles(5);
        chk("t1_level_early", btn_level, 4'b0000);
        cycles(1);
        chk("t1_level_6th", btn_level, 4'b1111);
        pins = 4'b0000;
        cycles(10);
        do_read();
        cycles(2);

        // 2: 3-cycle glitch on button0 is rejected
        pins = 4'b0001;
        cycles(3);
        pins = 4'b0000;
        for (int i = 0; i < 10; i++) begin
            cycles(1);
            chk("t2_level0", {3'b000, btn_level[0]}, 4'b0000);
            chk("t2_evt", {3'b000, evt_pending}, 4'b0000);
        end

        // 3: long press of button2, release, read, read again
        pins = 4'b0100;
        cycles(20);
        pins = 4'b0000;
        cycles(8);
        do_read();
        #2;
        chk("t3_in_data", bus_if.in_data, 4'b0100);
        chk("t3_valid", {3'b000, bus_if.in_valid}, 4'b0001);
        cycles(1);
        chk("t3_valid_drop", {3'b000, bus_if.in_valid}, 4'b0000);
        chk("t3_evt", {3'b000, evt_pending}, 4'b0000);
        do_read();
        #2;
        chk("t3_second_read", bus_if.in_data, 4'b0000);
        cycles(1);

        // 4: read lands on the edge where btn_level[1] rises
        pins = 4'b0010;
        cycles(5);
        do_read();
        #2;
        chk("t4_in_data_old", bus_if.in_data, 4'b0000);
        chk("t4_evt", {3'b000, evt_pending}, 4'b0001);
        pins = 4'b0000;
        cycles(8);
        do_read();
        #2;
        chk("t4_latch_kept", bus_if.in_data, 4'b0010);
        cycles(1);

        // 5: simultaneous OUT write and IN read
        pins = 4'b0001;
        cycles(8);
        bus_if.out_wr = 1'b1; bus_if.out_data = 4'b1010;
        do_read();
        bus_if.out_wr = 1'b0;
        #2;
        chk("t5_ff_out", ff_out, 4'b1010);
        chk("t5_in_data", bus_if.in_data, 4'b0001);
        chk("t5_valid", {3'b000, bus_if.in_valid}, 4'b0001);
        pins = 4'b0000;
        cycles(8);
        do_read();
        cycles(1);

        // 6: reset in the middle of a debounce count restarts it
        pins = 4'b0010;
        cycles(4);
        reset = 1'b0;
        cycles(1);
        reset = 1'b1;
        cycles(5);
        chk("t6_no_early", btn_level, 4'b0000);
        cycles(1);
        chk("t6_level", btn_level, 4'b0010);

        // randomized traffic
        hold_cnt = 0;
        for (int c = 0; c < 3000; c++) begin
            if (hold_cnt == 0) begin
                pins     = W'($urandom_range(0, 15));
                hold_cnt = $urandom_range(1, 9);
            end else begin
                hold_cnt--;
            end
            bus_if.in_rd    = ($urandom_range(0, 5) == 0);
            bus_if.out_wr   = ($urandom_range(0, 4) == 0);
            bus_if.out_data = W'($urandom_range(0, 15));
            reset           = ($urandom_range(0, 149) != 0);
            cycles(1);
        end
        bus_if.in_rd = 1'b0; bus_if.out_wr = 1'b0; reset = 1'b1;
        cycles(3);
        chk("scoreboard_drained", W'(exp_q.size()), 4'b0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
